// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a registered-output sync FIFO.
// Pops one byte per frame and shifts it out LSB-first on o_tx.
module fifo_uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_pop,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                r_state;
  state_e                w_next_state;
  logic [CNT_W-1:0]      r_baud_cnt;
  logic [2:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  w_baud_last;
  logic                  w_counting;

  assign w_baud_last = (r_baud_cnt == BAUD_LAST);
  assign w_counting  = (r_state == StStart) || (r_state == StData) || (r_state == StStop);

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:  if (!i_fifo_empty) w_next_state = StPop;
      StPop:   w_next_state = StLoad;
      // FIFO output is registered: the popped byte is valid during LOAD
      StLoad:  w_next_state = StStart;
      StStart: if (w_baud_last) w_next_state = StData;
      StData:  if (w_baud_last && (r_bit_cnt == 3'd7)) w_next_state = StStop;
      StStop:  if (w_baud_last) w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state <= w_next_state;

      if ((w_next_state != r_state) || w_baud_last || !w_counting) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
      end

      if (r_state == StStart) begin
        r_bit_cnt <= '0;
      end else if ((r_state == StData) && w_baud_last) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (r_state == StLoad) begin
        r_shift <= i_fifo_data;
      end else if ((r_state == StData) && w_baud_last) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    o_tx       = 1'b1;
    o_busy     = (r_state != StIdle);
    o_fifo_pop = (r_state == StPop);
    o_tx_done  = (r_state == StStop) && w_baud_last;
    unique case (r_state)
      StStart: o_tx = 1'b0;
      StData:  o_tx = r_shift[0];
      default: o_tx = 1'b1;
    endcase
  end

endmodule
